// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// One operation is in flight at a time: IDLE (grant) -> EXEC (ALU evaluates
// latched operands) -> RESP (result held until the winning port accepts it).
//
// Handshake rule for every req/rsp pair: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid and its
// payload stable until that edge. reqN_ready is high only in IDLE and only for
// the granted port. rspN_valid, rsp_y and the flags hold until rspN_ready is
// sampled high.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int FAIR  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             busy,
  output logic [15:0]      op_count,
  output logic [1:0]       dbg_state,
  output logic             dbg_rr_ptr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   rr_ptr;   // port preferred when both request (round-robin only)
  logic   port_id;  // port that owns the in-flight operation
  logic   gnt0;
  logic   gnt1;
  logic   req_hs;
  logic   rsp_hs;

  // Arbitration: a lone requester always wins; on contention the round-robin
  // pointer decides when FAIR is set, otherwise port 0 has fixed priority.
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || ((FAIR != 0) && rr_ptr));
    gnt0 = req0_valid && !gnt1;
  end

  // Next-state and handshake outputs; everything defaults to idle/inactive.
  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    req_hs     = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        // A grant implies the matching valid, so a grant is a handshake.
        if (gnt0 || gnt1) begin
          req_hs   = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nx = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = !port_id;
        rsp1_valid = port_id;
        rsp_hs     = port_id ? rsp1_ready : rsp0_ready;
        if (rsp_hs) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand/function latch: the ALU inputs come straight from these
  // registers and hold their last value outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_f   <= 3'b000;
      port_id <= 1'b0;
    end else if (req_hs) begin
      port_id <= gnt1;
      alu_a   <= gnt1 ? req1_a : req0_a;
      alu_b   <= gnt1 ? req1_b : req0_b;
      alu_f   <= gnt1 ? req1_f : req0_f;
    end
  end

  // Result capture at the end of the single EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_y        <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_y        <= alu_y;
      rsp_overflow <= alu_overflow;
      rsp_zero     <= alu_zero;
    end
  end

  // Completion bookkeeping: count finished ops (wrapping) and hand the
  // preference to the port that was not just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= 16'd0;
      rr_ptr   <= 1'b0;
    end else if (rsp_hs) begin
      op_count <= op_count + 16'd1;
      if (FAIR != 0) begin
        rr_ptr <= !port_id;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance (dut) and a fixed-priority
// instance (dut_fp) share the request/response inputs, each driving its own
// copy of a behavioural ALU. Inputs change 2 ns after posedge; outputs are
// sampled on negedge.
module tb_alu_arbiter;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_f = '0, req1_f = '0;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  // ---------------- round-robin DUT ----------------
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_y, alu_a, alu_b, alu_y;
  logic         rsp_overflow, rsp_zero, alu_overflow, alu_zero, busy, dbg_rr_ptr;
  logic [2:0]   alu_f;
  logic [15:0]  op_count;
  logic [1:0]   dbg_state;

  // ---------------- fixed-priority DUT ----------------
  logic         fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [W-1:0] fp_rsp_y, fp_alu_a, fp_alu_b, fp_alu_y;
  logic         fp_rsp_overflow, fp_rsp_zero, fp_alu_overflow, fp_alu_zero, fp_busy, fp_rr_ptr;
  logic [2:0]   fp_alu_f;
  logic [15:0]  fp_op_count;
  logic [1:0]   fp_state;

  alu_arbiter #(.WIDTH(W), .FAIR(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_y(rsp_y), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  alu_arbiter #(.WIDTH(W), .FAIR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_y(fp_rsp_y), .rsp_overflow(fp_rsp_overflow), .rsp_zero(fp_rsp_zero),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_f(fp_alu_f),
    .alu_y(fp_alu_y), .alu_overflow(fp_alu_overflow), .alu_zero(fp_alu_zero),
    .busy(fp_busy), .op_count(fp_op_count), .dbg_state(fp_state), .dbg_rr_ptr(fp_rr_ptr)
  );

  // External ALU: returns {overflow, zero, y}; unknown codes yield 0.
  function automatic logic [W+1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] f);
    logic [W-1:0] y;
    logic         ov;
    y  = '0;
    ov = 1'b0;
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: begin
        y  = a + b;
        ov = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b110: begin
        y  = a - b;
        ov = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b111: y = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      default: y = '0;
    endcase
    return {ov, (y == '0), y};
  endfunction

  assign {alu_overflow, alu_zero, alu_y}          = alu_model(alu_a, alu_b, alu_f);
  assign {fp_alu_overflow, fp_alu_zero, fp_alu_y} = alu_model(fp_alu_a, fp_alu_b, fp_alu_f);

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_rr  = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] fp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   f;
    logic [W-1:0] y;
    logic         ov;
    logic         z;
    int           stall;  // extra cycles rsp ready stays low
    logic         bg;     // port 0 also requests while this port-1 op runs
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset   = 1'b0;
    exp_cnt = 16'd0;
    exp_rr  = 1'b0;
  endtask

  // Present a request (optionally with a competing port-0 request) and
  // return 2 ns after the handshake edge with the request withdrawn.
  task automatic start_op(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] f, input logic bg, input string tag, output logic ok);
    logic other;
    @(posedge clk); #2;
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
    end
    if (bg) begin
      req0_valid = 1'b1; req0_a = 32'h1111_0000; req0_b = 32'h0000_2222; req0_f = 3'b001;
    end
    ok    = 1'b0;
    other = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok    = port ? req1_ready : req0_ready;
      other = port ? req0_ready : req1_ready;
    end
    check({tag, "_grant"}, 32'(ok), 32'd1);
    check({tag, "_excl"}, 32'(other), 32'd0);
    @(posedge clk); #2;
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic ok;
    logic vld, nvld;
    if (v.port) rsp1_ready = (v.stall == 0);
    else        rsp0_ready = (v.stall == 0);
    start_op(v.port, v.a, v.b, v.f, v.bg, tag, ok);
    if (!ok) begin
      rsp0_ready = 1'b0; rsp1_ready = 1'b0; req0_valid = 1'b0;
      return;
    end
    // EXEC: ALU driven from the latched operands, no response yet.
    @(negedge clk);
    check({tag, "_exec_state"}, 32'(dbg_state), 32'd1);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_rspv"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check({tag, "_alu_a"}, alu_a, v.a);
    check({tag, "_alu_b"}, alu_b, v.b);
    check({tag, "_alu_f"}, 32'(alu_f), 32'(v.f));
    // RESP: two cycles after the handshake edge.
    @(negedge clk);
    vld  = v.port ? rsp1_valid : rsp0_valid;
    nvld = v.port ? rsp0_valid : rsp1_valid;
    check({tag, "_rsp_valid"}, 32'(vld), 32'd1);
    check({tag, "_rsp_other"}, 32'(nvld), 32'd0);
    check({tag, "_y"}, rsp_y, v.y);
    check({tag, "_ov"}, 32'(rsp_overflow), 32'(v.ov));
    check({tag, "_z"}, 32'(rsp_zero), 32'(v.z));
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      vld = v.port ? rsp1_valid : rsp0_valid;
      check({tag, "_hold_valid"}, 32'(vld), 32'd1);
      check({tag, "_hold_y"}, rsp_y, v.y);
      check({tag, "_hold_req0_ready"}, 32'(req0_ready), 32'd0);
    end
    if (v.stall > 0) begin
      @(posedge clk); #2;
      if (v.port) rsp1_ready = 1'b1;
      else        rsp0_ready = 1'b1;
    end
    @(posedge clk); #2;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    if (v.bg) req0_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    exp_rr  = !v.port;
    @(negedge clk);
    check({tag, "_done_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_done_rspv"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'(exp_cnt));
    check({tag, "_rr_ptr"}, 32'(dbg_rr_ptr), 32'(exp_rr));
    if (v.bg) begin
      // The competing request was withdrawn before any grant: never served.
      repeat (2) @(negedge clk);
      check({tag, "_stale_busy"}, 32'(busy), 32'd0);
      check({tag, "_stale_count"}, 32'(op_count), 32'(exp_cnt));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rspv"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
    check({tag, "_rr_ptr"}, 32'(dbg_rr_ptr), 32'd0);
    check({tag, "_rsp_y"}, rsp_y, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    vec_t wrap_v;

    //           port  a              b              f       y              ov    z     stall bg
    vecs[0] = '{1'b0, 32'd5,         32'd3,         3'b010, 32'd8,         1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 32'd3,         32'd3,         3'b110, 32'd0,         1'b0, 1'b1, 0, 1'b0};
    vecs[2] = '{1'b1, 32'h7FFFFFFF,  32'd1,         3'b010, 32'h80000000,  1'b1, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000F0F0,  32'h0000FF00,  3'b000, 32'h0000F000,  1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000F0F0,  32'h00000F0F,  3'b001, 32'h0000FFFF,  1'b0, 1'b0, 0, 1'b0};
    vecs[5] = '{1'b0, 32'hFFFFFFFF,  32'd1,         3'b111, 32'd1,         1'b0, 1'b0, 0, 1'b0};
    vecs[6] = '{1'b0, 32'd1,         32'hFFFFFFFF,  3'b111, 32'd0,         1'b0, 1'b1, 0, 1'b0};
    vecs[7] = '{1'b1, 32'h80000000,  32'd1,         3'b110, 32'h7FFFFFFF,  1'b1, 1'b0, 0, 1'b0};
    vecs[8] = '{1'b0, 32'd2,         32'd5,         3'b110, 32'hFFFFFFFD,  1'b0, 1'b0, 0, 1'b0};
    vecs[9] = '{1'b1, 32'd3,         32'd4,         3'b011, 32'd0,         1'b0, 1'b1, 5, 1'b1};

    // Reset values.
    do_reset();
    @(negedge clk);
    check_reset_state("reset");
    check("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_f", 32'(alu_f), 32'd0);

    // Table: single ops, flags, SLT, unknown F code, backpressure with a
    // competing port-0 request that gives up before being granted.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Both ports continuously valid: round-robin alternates, fixed priority
    // keeps serving port 0 and starves port 1.
    do_reset();
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    got_q.delete();
    fp_q.delete();
    @(posedge clk); #2;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_f = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_f = 3'b010;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) got_q.push_back(32'd0);
      if (req1_valid && req1_ready) got_q.push_back(32'd1);
      if (req0_valid && fp_req0_ready) fp_q.push_back(32'd0);
      if (req1_valid && fp_req1_ready) fp_q.push_back(32'd1);
    end
    @(posedge clk); #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rr_grants", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_order%0d", i), (got_q.size() > 0) ? got_q.pop_front() : 32'hDEAD, exp_q[i]);
    end
    check("rr_op_count", 32'(op_count), 32'd4);
    check("fp_grants", 32'(fp_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp_order%0d", i), (fp_q.size() > 0) ? fp_q.pop_front() : 32'hDEAD, 32'd0);
    end
    check("fp_op_count", 32'(fp_op_count), 32'd4);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset during EXEC.
    do_reset();
    run_op('{1'b0, 32'd1, 32'd1, 3'b010, 32'd2, 1'b0, 1'b0, 0, 1'b0}, "pre_exec");
    start_op(1'b1, 32'd9, 32'd4, 3'b110, 1'b0, "rst_exec", ok);
    reset = 1'b1;
    @(negedge clk);
    check("rst_exec_in_exec", 32'(dbg_state), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst_exec");
    exp_cnt = 16'd0;
    exp_rr  = 1'b0;

    // Reset during RESP with the response never accepted.
    run_op('{1'b1, 32'd6, 32'd6, 3'b000, 32'd6, 1'b0, 1'b0, 0, 1'b0}, "pre_resp");
    start_op(1'b0, 32'd7, 32'd2, 3'b001, 1'b0, "rst_resp", ok);
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_in_resp", 32'(rsp0_valid), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst_resp");
    exp_cnt = 16'd0;
    exp_rr  = 1'b0;

    // Counter wrap: preload the count, then one SLT op (-1 < 1).
    @(negedge clk);
    dut.op_count = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    wrap_v = '{1'b0, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0, 0, 1'b0};
    run_op(wrap_v, "wrap");
    check("wrap_zero", 32'(op_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
